// File: rtl/rtc_access_scheduler.sv
// rtl/rtc_access_scheduler.sv - shares the RTC bus-cycle engine between a periodic refresh sweep and a user write port
// Read data lands in a shadow bank and is published to rd_bank only when a sweep completes.
module rtc_access_scheduler #(
   parameter int         N_READ_REGS = 3,
   parameter logic [7:0] READ_BASE   = 8'h21,
   parameter int         REFRESH_DIV = 10_000_000,
   parameter int         TIMEOUT     = 255
) (
   input  logic                     Clock_in,
   input  logic                     Reset,
   input  logic                     wr_req,
   input  logic [7:0]               wr_addr,
   input  logic [7:0]               wr_data,
   output logic                     wr_ack,
   output logic                     cyc_start,
   output logic                     cyc_write,
   output logic [7:0]               cyc_addr,
   output logic [7:0]               cyc_wdata,
   input  logic                     cyc_done,
   input  logic [7:0]               cyc_rdata,
   output logic [8*N_READ_REGS-1:0] rd_bank,
   output logic                     rd_valid,
   output logic                     busy,
   output logic                     timeout_err
);

   localparam int IDX_W  = (N_READ_REGS > 1) ? $clog2(N_READ_REGS) : 1;
   localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(REFRESH_DIV - 1);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(N_READ_REGS - 1);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] ISSUE   = 3'd1;
   localparam logic [2:0] WAIT    = 3'd2;
   localparam logic [2:0] CAPTURE = 3'd3;
   localparam logic [2:0] SELECT  = 3'd4;
   localparam logic [2:0] ABORT   = 3'd5;

   logic [2:0]        state;
   logic [CNT_W-1:0]  refresh_cnt;
   logic              tick;
   logic              sweep_pending;
   logic              sweep_active;
   logic [IDX_W-1:0]  index;
   logic [WAIT_W-1:0] wait_cnt;
   logic [7:0]        shadow [N_READ_REGS];
   logic              sweep_last;
   logic [7:0]        next_read_addr;

   assign tick           = (refresh_cnt == '0);
   assign busy           = (state != IDLE);
   // A write never interleaves after the final read, so a read at LAST_IDX closes the sweep.
   assign sweep_last     = sweep_active && !cyc_write && (index == LAST_IDX);
   assign next_read_addr = READ_BASE + 8'(index) + 8'd1;

   always_ff @(posedge Clock_in or posedge Reset) begin
      if (Reset) begin
         refresh_cnt <= CNT_RELOAD;
      end else if (tick) begin
         refresh_cnt <= CNT_RELOAD;
      end else begin
         refresh_cnt <= refresh_cnt - 1'b1;
      end
   end

   always_ff @(posedge Clock_in or posedge Reset) begin
      if (Reset) begin
         state         <= IDLE;
         sweep_pending <= 1'b0;
         sweep_active  <= 1'b0;
         index         <= '0;
         wait_cnt      <= '0;
         cyc_start     <= 1'b0;
         cyc_write     <= 1'b0;
         cyc_addr      <= 8'h00;
         cyc_wdata     <= 8'h00;
         wr_ack        <= 1'b0;
         rd_valid      <= 1'b0;
         timeout_err   <= 1'b0;
         rd_bank       <= '0;
         for (int i = 0; i < N_READ_REGS; i++) begin
            shadow[i] <= 8'h00;
         end
      end else begin
         cyc_start <= 1'b0;
         wr_ack    <= 1'b0;
         rd_valid  <= 1'b0;

         // Ticks landing while a sweep is queued or running fold into the same sweep_pending.
         if (tick) begin
            sweep_pending <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (wr_req) begin
                  cyc_write <= 1'b1;
                  cyc_addr  <= wr_addr;
                  cyc_wdata <= wr_data;
                  state     <= ISSUE;
               end else if (sweep_pending) begin
                  cyc_write    <= 1'b0;
                  cyc_addr     <= READ_BASE;
                  cyc_wdata    <= 8'h00;
                  index        <= '0;
                  sweep_active <= 1'b1;
                  state        <= ISSUE;
               end
            end

            ISSUE: begin
               cyc_start <= 1'b1;
               wait_cnt  <= '0;
               state     <= WAIT;
            end

            WAIT: begin
               if (cyc_done) begin
                  if (cyc_write) begin
                     wr_ack <= 1'b1;
                  end else begin
                     shadow[index] <= cyc_rdata;
                  end
                  timeout_err <= 1'b0;
                  state       <= CAPTURE;
               end else if (wait_cnt == WAIT_LIMIT) begin
                  timeout_err <= 1'b1;
                  state       <= ABORT;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            CAPTURE: begin
               if (sweep_last) begin
                  for (int i = 0; i < N_READ_REGS; i++) begin
                     rd_bank[i*8 +: 8] <= shadow[i];
                  end
                  rd_valid <= 1'b1;
               end
               state <= SELECT;
            end

            SELECT: begin
               if (!sweep_active) begin
                  state <= IDLE;
               end else if (sweep_last) begin
                  sweep_active  <= 1'b0;
                  sweep_pending <= 1'b0;
                  index         <= '0;
                  state         <= IDLE;
               end else if (wr_req) begin
                  cyc_write <= 1'b1;
                  cyc_addr  <= wr_addr;
                  cyc_wdata <= wr_data;
                  state     <= ISSUE;
               end else begin
                  index     <= index + 1'b1;
                  cyc_write <= 1'b0;
                  cyc_addr  <= next_read_addr;
                  cyc_wdata <= 8'h00;
                  state     <= ISSUE;
               end
            end

            ABORT: begin
               sweep_active  <= 1'b0;
               sweep_pending <= 1'b0;
               index         <= '0;
               state         <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rtc_access_scheduler.sv
// tb/tb_rtc_access_scheduler.sv - directed self-checking bench for rtc_access_scheduler
// Engine model answers each cyc_start after eng_delay cycles from a small register image.
module tb_rtc_access_scheduler;

   logic        Clock_in = 1'b0;
   logic        Reset    = 1'b1;
   logic        wr_req   = 1'b0;
   logic [7:0]  wr_addr  = 8'h00;
   logic [7:0]  wr_data  = 8'h00;
   logic        wr_ack;
   logic        cyc_start;
   logic        cyc_write;
   logic [7:0]  cyc_addr;
   logic [7:0]  cyc_wdata;
   logic        cyc_done  = 1'b0;
   logic [7:0]  cyc_rdata = 8'h00;
   logic [23:0] rd_bank;
   logic        rd_valid;
   logic        busy;
   logic        timeout_err;

   always #5 Clock_in = ~Clock_in;

   rtc_access_scheduler #(
      .N_READ_REGS (3),
      .READ_BASE   (8'h21),
      .REFRESH_DIV (50),
      .TIMEOUT     (20)
   ) dut (
      .Clock_in    (Clock_in),
      .Reset       (Reset),
      .wr_req      (wr_req),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_ack      (wr_ack),
      .cyc_start   (cyc_start),
      .cyc_write   (cyc_write),
      .cyc_addr    (cyc_addr),
      .cyc_wdata   (cyc_wdata),
      .cyc_done    (cyc_done),
      .cyc_rdata   (cyc_rdata),
      .rd_bank     (rd_bank),
      .rd_valid    (rd_valid),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   int cyc_n   = 0;
   int n_rdv   = 0;
   int n_ack   = 0;
   int rdv_cyc = 0;
   int ack_cyc = 0;
   int done_cyc = 0;

   always @(posedge Clock_in) begin
      cyc_n <= cyc_n + 1;
      if (rd_valid) begin
         n_rdv   <= n_rdv + 1;
         rdv_cyc <= cyc_n;
      end
      if (wr_ack) begin
         n_ack   <= n_ack + 1;
         ack_cyc <= cyc_n;
      end
      if (cyc_done) done_cyc <= cyc_n;
   end

   logic [7:0] mem [256];
   int         eng_delay = 6;
   logic       hold_en   = 1'b0;
   logic [7:0] hold_addr = 8'h00;
   logic [7:0] log_addr [$];
   logic       log_wr   [$];
   logic [7:0] log_wd   [$];
   logic [7:0] eng_a;
   logic       eng_w;

   initial begin
      forever begin
         @(negedge Clock_in);
         if (cyc_start) begin
            eng_a = cyc_addr;
            eng_w = cyc_write;
            log_addr.push_back(cyc_addr);
            log_wr.push_back(cyc_write);
            log_wd.push_back(cyc_wdata);
            if (!(hold_en && eng_a == hold_addr)) begin
               repeat (eng_delay) @(negedge Clock_in);
               if (busy) begin
                  check("addr_stable", cyc_addr, eng_a);
                  check("dir_stable", cyc_write, eng_w);
               end
               cyc_done  = 1'b1;
               cyc_rdata = eng_w ? 8'h00 : mem[eng_a];
               @(negedge Clock_in);
               cyc_done  = 1'b0;
               cyc_rdata = 8'h00;
            end
         end
      end
   end

   task automatic clear_log();
      log_addr.delete();
      log_wr.delete();
      log_wd.delete();
   endtask

   // which: 0 rd_valid, 1 wr_ack, 2 cyc_start at addr a, 3 timeout_err, other any cyc_start
   task automatic wait_for(input int which, input logic [7:0] a, input int bound, input string tag);
      int   k;
      logic hit;
      hit = 1'b0;
      k   = 0;
      while (!hit && k < bound) begin
         @(negedge Clock_in);
         k++;
         case (which)
            0:       hit = rd_valid;
            1:       hit = wr_ack;
            2:       hit = cyc_start && (cyc_addr == a);
            3:       hit = timeout_err;
            default: hit = cyc_start;
         endcase
      end
      check(tag, hit, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   logic [7:0] exp_addr [4];
   logic       exp_wr   [4];
   int         mark;

   initial begin
      repeat (3) @(negedge Clock_in);
      check("rst_busy", busy, 1'b0);
      check("rst_pulses", {cyc_start, cyc_write, wr_ack, rd_valid, timeout_err}, 5'b0);
      check("rst_bank", rd_bank, 24'h0);
      check("rst_addr_data", {cyc_addr, cyc_wdata}, 16'h0);

      // Idle refresh sweep
      mem[8'h21] = 8'h59; mem[8'h22] = 8'h07; mem[8'h23] = 8'h12;
      clear_log();
      Reset = 1'b0;
      wait_for(0, 8'h00, 200, "sweep1_rdv");
      @(negedge Clock_in);
      check("sweep1_ncyc", log_addr.size(), 3);
      for (int i = 0; i < 3; i++) begin
         check("sweep1_addr", log_addr[i], 8'h21 + i);
         check("sweep1_rd", log_wr[i], 1'b0);
      end
      check("sweep1_bank", rd_bank, 24'h120759);
      check("sweep1_nrdv", n_rdv, 1);
      check("rdv_latency", rdv_cyc - done_cyc, 2);
      check("sweep1_idle", busy, 1'b0);

      // Write alone, from IDLE
      clear_log();
      wr_req = 1'b1; wr_addr = 8'h22; wr_data = 8'h30;
      @(negedge Clock_in);
      check("wr_start_early", cyc_start, 1'b0);
      @(negedge Clock_in);
      check("wr_start", cyc_start, 1'b1);
      check("wr_fields", {cyc_write, cyc_addr, cyc_wdata}, {1'b1, 8'h22, 8'h30});
      wait_for(1, 8'h00, 30, "wr_ack");
      wr_req = 1'b0;
      @(negedge Clock_in);
      check("ack_latency", ack_cyc - done_cyc, 1);
      check("ack_count", n_ack, 1);

      // Write arriving while the read of 0x21 is in WAIT
      mem[8'h21] = 8'hAA; mem[8'h22] = 8'hBB; mem[8'h23] = 8'hCC;
      clear_log();
      wait_for(2, 8'h21, 100, "sw2_start");
      wr_req = 1'b1; wr_addr = 8'h40; wr_data = 8'hA5;
      wait_for(1, 8'h00, 60, "sw2_ack");
      wr_req = 1'b0;
      wait_for(0, 8'h00, 100, "sw2_rdv");
      @(negedge Clock_in);
      exp_addr[0] = 8'h21; exp_addr[1] = 8'h40; exp_addr[2] = 8'h22; exp_addr[3] = 8'h23;
      exp_wr[0] = 1'b0; exp_wr[1] = 1'b1; exp_wr[2] = 1'b0; exp_wr[3] = 1'b0;
      check("sw2_ncyc", log_addr.size(), 4);
      for (int i = 0; i < 4; i++) begin
         check("sw2_order_addr", log_addr[i], exp_addr[i]);
         check("sw2_order_dir", log_wr[i], exp_wr[i]);
      end
      check("sw2_wdata", log_wd[1], 8'hA5);
      check("sw2_bank", rd_bank, 24'hCCBBAA);
      check("sw2_nrdv", n_rdv, 2);
      check("sw2_nack", n_ack, 2);

      // Timeout on the read of 0x22
      mem[8'h21] = 8'h01; mem[8'h22] = 8'h02; mem[8'h23] = 8'h03;
      hold_en = 1'b1; hold_addr = 8'h22;
      wait_for(2, 8'h22, 120, "to_start");
      mark = cyc_n;
      wait_for(3, 8'h00, 40, "to_err");
      check("to_latency", cyc_n - mark, 20);
      @(negedge Clock_in);
      check("to_idle", busy, 1'b0);
      check("to_sticky", timeout_err, 1'b1);
      check("to_bank_kept", rd_bank, 24'hCCBBAA);
      check("to_no_rdv", n_rdv, 2);
      hold_en = 1'b0;
      mem[8'h21] = 8'h5A; mem[8'h22] = 8'h6B; mem[8'h23] = 8'h7C;
      wait_for(0, 8'h00, 150, "rec_rdv");
      check("rec_err_clear", timeout_err, 1'b0);
      check("rec_bank", rd_bank, 24'h7C6B5A);

      // Slow engine: sweep outlasts the tick period
      @(negedge Clock_in);
      eng_delay = 17;
      wait_for(0, 8'h00, 200, "ov_rdv1");
      mark = cyc_n;
      clear_log();
      wait_for(4, 8'h00, 100, "ov_next");
      check("ov_gap", cyc_n - mark, 39);
      wait_for(0, 8'h00, 200, "ov_rdv2");
      @(negedge Clock_in);
      check("ov_ncyc", log_addr.size(), 3);
      check("ov_nrdv", n_rdv, 5);

      // Reset in the middle of WAIT
      eng_delay = 6;
      wait_for(4, 8'h00, 100, "rs_start");
      repeat (2) @(negedge Clock_in);
      Reset = 1'b1;
      #1;
      check("rs_busy", busy, 1'b0);
      check("rs_pulses", {cyc_start, cyc_write, wr_ack, rd_valid, timeout_err}, 5'b0);
      check("rs_addr_data", {cyc_addr, cyc_wdata}, 16'h0);
      check("rs_bank", rd_bank, 24'h0);
      repeat (3) @(negedge Clock_in);
      Reset = 1'b0;
      clear_log();
      repeat (40) @(negedge Clock_in);
      check("rs_quiet", log_addr.size(), 0);
      wr_req = 1'b1; wr_addr = 8'h23; wr_data = 8'h44;
      wait_for(1, 8'h00, 30, "rs_ack");
      wr_req = 1'b0;
      check("rs_first_cyc", log_addr.size(), 1);
      check("rs_first_addr", log_addr[0], 8'h23);
      repeat (3) @(negedge Clock_in);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
